// File: rtl/sipo_deser_if.sv
// Bus bundle for the serial-to-parallel receiver.
//   s_data/s_valid : serial bit stream, one bit per s_valid cycle
//   sync_clr       : discard the partial word and restart the bit count
//   p_data/p_valid : assembled word and its one-entry buffer flag
//   p_ready        : downstream accepts the word when p_valid && p_ready
//   bit_cnt        : bits collected so far in the current partial word
//   overrun        : sticky dropped-word flag; overrun_clr clears it
// The slave modport is the receiver; the master modport is whoever drives
// the stream and consumes the words.
interface sipo_deser_if #(
  parameter int N = 8
) ();
  logic                   s_data;
  logic                   s_valid;
  logic                   sync_clr;
  logic [N-1:0]           p_data;
  logic                   p_valid;
  logic                   p_ready;
  logic [$clog2(N)-1:0]   bit_cnt;
  logic                   overrun;
  logic                   overrun_clr;

  modport slave (
    input  s_data, s_valid, sync_clr, p_ready, overrun_clr,
    output p_data, p_valid, bit_cnt, overrun
  );

  modport master (
    output s_data, s_valid, sync_clr, p_ready, overrun_clr,
    input  p_data, p_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-to-parallel receiver. Collects N serial bits into a word and hands
// each completed word to a one-entry valid/ready holding buffer. A word that
// completes while the buffer is full and not draining is dropped and raises
// the sticky overrun flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears all state
//   bus  : sipo_deser_if slave modport (stream in, word out, status)
// Parameters:
//   N         : word width (>= 2)
//   LSB_FIRST : 1 -> first bit lands in p_data[0]; 0 -> in p_data[N-1]
module sipo_deser #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  sr, sr_nx;
  logic [N-1:0]  word;
  logic [N-1:0]  data_q, data_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ovr, ovr_nx, ovr_set;
  logic          accept, complete, drain;

  // Bit collection: the shift direction decides where the first bit ends up
  // after N accepts. The completed word is the shifted value including the
  // bit being accepted this cycle, so it can be loaded on the same edge.
  always_comb begin
    accept   = bus.s_valid && !bus.sync_clr;
    complete = accept && (cnt == LAST);
    drain    = (state == FULL) && bus.p_ready;

    if (LAST_FIRST_SEL()) word = {bus.s_data, sr[N-1:1]};
    else                  word = {sr[N-2:0], bus.s_data};

    sr_nx  = sr;
    cnt_nx = cnt;
    if (bus.sync_clr) begin
      sr_nx  = '0;
      cnt_nx = '0;
    end else if (accept) begin
      sr_nx  = word;
      cnt_nx = complete ? '0 : cnt + 1'b1;
    end
  end

  function automatic bit LAST_FIRST_SEL();
    return LSB_FIRST;
  endfunction

  // Holding buffer FSM. FULL with a coincident completion either refills
  // (downstream draining this cycle) or drops the new word and flags overrun.
  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    ovr_set  = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          data_nx  = word;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (drain) data_nx = word;
          else       ovr_set = 1'b1;
        end else if (drain) begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // A new overrun beats a simultaneous clear.
    ovr_nx = ovr_set | (ovr & ~bus.overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      sr     <= '0;
      cnt    <= '0;
      data_q <= '0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      data_q <= data_nx;
      ovr    <= ovr_nx;
    end
  end

  assign bus.p_data  = data_q;
  assign bus.p_valid = (state == FULL);
  assign bus.bit_cnt = cnt;
  assign bus.overrun = ovr;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser. Two instances share the same stimulus:
// dut_a uses LSB_FIRST=1, dut_b uses LSB_FIRST=0.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.N(8)) ifa ();
  sipo_deser_if #(.N(8)) ifb ();

  assign ifb.s_data      = ifa.s_data;
  assign ifb.s_valid     = ifa.s_valid;
  assign ifb.sync_clr    = ifa.sync_clr;
  assign ifb.p_ready     = ifa.p_ready;
  assign ifb.overrun_clr = ifa.overrun_clr;

  sipo_deser #(.N(8), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sipo_deser #(.N(8), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send bits 0..nbits-1 of w, one per cycle, s_valid held high.
  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      ifa.s_valid = 1'b1;
      ifa.s_data  = w[k];
      tick();
    end
    ifa.s_valid = 1'b0;
    ifa.s_data  = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst             = 1'b1;
    ifa.s_data      = 1'b0;
    ifa.s_valid     = 1'b0;
    ifa.sync_clr    = 1'b0;
    ifa.p_ready     = 1'b1;
    ifa.overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst_p_valid", 32'(ifa.p_valid), 32'd0);
    chk("rst_bit_cnt", 32'(ifa.bit_cnt), 32'd0);
    chk("rst_overrun", 32'(ifa.overrun), 32'd0);
    chk("rst_p_data",  32'(ifa.p_data),  32'h00);
    rst = 1'b0;
    tick();

    // Bits 1,0,1,0,0,1,0,1 -> A5 in both bit orders.
    send_bits(8'hA5, 7);
    chk("a5_not_yet", 32'(ifa.p_valid), 32'd0);
    chk("a5_cnt7",    32'(ifa.bit_cnt), 32'd7);
    ifa.s_valid = 1'b1; ifa.s_data = 1'b1;
    tick();
    ifa.s_valid = 1'b0;
    chk("a5_valid",   32'(ifa.p_valid), 32'd1);
    chk("a5_data_a",  32'(ifa.p_data),  32'hA5);
    chk("a5_data_b",  32'(ifb.p_data),  32'hA5);
    chk("a5_cnt0",    32'(ifa.bit_cnt), 32'd0);
    tick();
    chk("a5_one_cyc", 32'(ifa.p_valid), 32'd0);

    // Bits 1,1,0,0,0,0,0,0: LSB-first gives 03, MSB-first gives C0.
    send_bits(8'h03, 8);
    chk("c0_data_a", 32'(ifa.p_data), 32'h03);
    chk("c0_data_b", 32'(ifb.p_data), 32'hC0);
    tick();
    chk("c0_drained", 32'(ifa.p_valid), 32'd0);

    // Back-pressure: second word dropped, overrun set and cleared.
    ifa.p_ready = 1'b0;
    send_bits(8'h3C, 8);
    chk("bp_valid1", 32'(ifa.p_valid), 32'd1);
    chk("bp_data1",  32'(ifa.p_data),  32'h3C);
    send_bits(8'hF0, 8);
    chk("bp_valid2", 32'(ifa.p_valid), 32'd1);
    chk("bp_hold",   32'(ifa.p_data),  32'h3C);
    chk("bp_ovr",    32'(ifa.overrun), 32'd1);
    chk("bp_ovr_b",  32'(ifb.overrun), 32'd1);
    tick();
    chk("bp_sticky", 32'(ifa.overrun), 32'd1);
    ifa.overrun_clr = 1'b1;
    tick();
    ifa.overrun_clr = 1'b0;
    chk("bp_ovr_clr", 32'(ifa.overrun), 32'd0);
    chk("bp_still",   32'(ifa.p_valid), 32'd1);
    ifa.p_ready = 1'b1;
    tick();
    chk("bp_drain",   32'(ifa.p_valid), 32'd0);
    chk("bp_keep",    32'(ifa.p_data),  32'h3C);

    // Overrun set coinciding with overrun_clr: set wins.
    ifa.p_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 7);
    ifa.s_valid = 1'b1; ifa.s_data = 1'b0; ifa.overrun_clr = 1'b1;
    tick();
    ifa.s_valid = 1'b0; ifa.overrun_clr = 1'b0;
    chk("setwin_ovr",  32'(ifa.overrun), 32'd1);
    chk("setwin_data", 32'(ifa.p_data),  32'h11);
    ifa.overrun_clr = 1'b1;
    ifa.p_ready     = 1'b1;
    tick();
    ifa.overrun_clr = 1'b0;
    chk("setwin_clr",  32'(ifa.overrun), 32'd0);
    chk("setwin_drn",  32'(ifa.p_valid), 32'd0);

    // Continuous stream of 01..04, p_ready high: one-cycle pulses, 8 apart.
    for (int wi = 1; wi <= 4; wi++) begin
      w = 8'(wi);
      for (int k = 0; k < 8; k++) begin
        ifa.s_valid = 1'b1;
        ifa.s_data  = w[k];
        tick();
        if (k == 0 && wi > 1) chk("str_gap", 32'(ifa.p_valid), 32'd0);
      end
      chk("str_valid", 32'(ifa.p_valid), 32'd1);
      chk("str_data",  32'(ifa.p_data),  32'(wi));
    end
    ifa.s_valid = 1'b0;
    chk("str_ovr", 32'(ifa.overrun), 32'd0);
    tick();

    // Same stream; p_ready low through word 4, raised on its completion edge.
    for (int wi = 1; wi <= 4; wi++) begin
      w = 8'(wi);
      for (int k = 0; k < 8; k++) begin
        if (wi == 4 && k == 0) ifa.p_ready = 1'b0;
        if (wi == 4 && k == 7) ifa.p_ready = 1'b1;
        ifa.s_valid = 1'b1;
        ifa.s_data  = w[k];
        tick();
        if (wi == 4 && k == 3) chk("dr_hold", 32'(ifa.p_data), 32'h03);
      end
      chk("dr_data", 32'(ifa.p_data), 32'(wi));
    end
    ifa.s_valid = 1'b0;
    chk("dr_valid", 32'(ifa.p_valid), 32'd1);
    chk("dr_ovr",   32'(ifa.overrun), 32'd0);
    tick();
    chk("dr_empty", 32'(ifa.p_valid), 32'd0);

    // sync_clr after 5 bits, with a 6th s_valid in the same cycle.
    send_bits(8'hFF, 5);
    ifa.s_valid = 1'b1; ifa.s_data = 1'b1; ifa.sync_clr = 1'b1;
    tick();
    ifa.s_valid = 1'b0; ifa.sync_clr = 1'b0;
    chk("sc_cnt", 32'(ifa.bit_cnt), 32'd0);
    send_bits(8'h5A, 7);
    chk("sc_nospur", 32'(ifa.p_valid), 32'd0);
    ifa.s_valid = 1'b1; ifa.s_data = 1'b0;
    tick();
    ifa.s_valid = 1'b0;
    chk("sc_data", 32'(ifa.p_data), 32'h5A);
    chk("sc_valid", 32'(ifa.p_valid), 32'd1);
    tick();

    // Reset mid-word with a full buffer and overrun set.
    ifa.p_ready = 1'b0;
    send_bits(8'h77, 8);
    send_bits(8'h88, 8);
    send_bits(8'h07, 3);
    chk("mr_pre_cnt", 32'(ifa.bit_cnt), 32'd3);
    chk("mr_pre_ovr", 32'(ifa.overrun), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(ifa.p_valid), 32'd0);
    chk("mr_cnt",   32'(ifa.bit_cnt), 32'd0);
    chk("mr_ovr",   32'(ifa.overrun), 32'd0);
    ifa.p_ready = 1'b1;
    tick();

    // s_valid every other cycle while sending 96; stalls hold bit_cnt.
    w = 8'h96;
    for (int k = 0; k < 8; k++) begin
      ifa.s_valid = 1'b1;
      ifa.s_data  = w[k];
      tick();
      ifa.s_valid = 1'b0;
      ifa.s_data  = ~w[k];
      chk("tg_cnt", 32'(ifa.bit_cnt), 32'((k + 1) % 8));
      if (k < 7) chk("tg_nvalid", 32'(ifa.p_valid), 32'd0);
      tick();
      if (k < 7) chk("tg_stall", 32'(ifa.bit_cnt), 32'(k + 1));
    end
    chk("tg_drained", 32'(ifa.p_valid), 32'd0);
    chk("tg_data",    32'(ifa.p_data),  32'h96);
    chk("tg_data_b",  32'(ifb.p_data),  32'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
